// File: rtl/ascon_round_ctrl.sv
// ASCON permutation round sequencer: one round per cycle, done_o one cycle after the last round.
// No backpressure: start_i is taken only in IDLE, abort_i cancels a run at any point.
module ascon_round_ctrl #(
  parameter int MAX_ROUNDS = 12,
  parameter int ROUND_W    = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [ROUND_W-1:0] rounds_i,
  input  logic               abort_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               sel_init_o,
  output logic               en_reg_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] MAX_R  = ROUND_W'(MAX_ROUNDS);
  localparam logic [ROUND_W-1:0] LAST_R = ROUND_W'(MAX_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] ONE_R  = ROUND_W'(1);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] nsat;

  assign nsat = (rounds_i > MAX_R) ? MAX_R : rounds_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    sel_init_o = 1'b0;
    en_reg_o   = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i && (rounds_i != '0) && !abort_i) begin
          state_d = S_FIRST;
          // Short runs use the tail of the constant table, so p^b ends on the same index as p^a.
          round_d = MAX_R - nsat;
        end
      end
      S_FIRST, S_RUN: begin
        busy_o     = 1'b1;
        en_reg_o   = !abort_i;
        sel_init_o = (state_q == S_FIRST) && !abort_i;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (round_q == LAST_R) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          round_d = round_q + ONE_R;
        end
      end
      S_DONE: begin
        done_o  = !abort_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign round_o = round_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl: per-cycle vector table plus back-to-back and reset-mid-run sequences.
module tb_ascon_round_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [3:0] rounds_i;
  logic       abort_i;
  logic       ready_o, busy_o, sel_init_o, en_reg_o, done_o;
  logic [3:0] round_o;

  int total = 0;
  int bad   = 0;

  ascon_round_ctrl #(.MAX_ROUNDS(12), .ROUND_W(4)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .rounds_i  (rounds_i),
    .abort_i   (abort_i),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .round_o   (round_o),
    .sel_init_o(sel_init_o),
    .en_reg_o  (en_reg_o),
    .done_o    (done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       start;
    logic [3:0] rounds;
    logic       abort;
    logic       ready;
    logic       busy;
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic       done;
  } vec_t;

  vec_t vq[$];

  function automatic void push(input logic s, input logic [3:0] r, input logic a,
                               input logic rdy, input logic b, input logic [3:0] rd,
                               input logic sl, input logic e, input logic d);
    vec_t v;
    v.start = s; v.rounds = r; v.abort = a;
    v.ready = rdy; v.busy = b; v.round = rd; v.sel = sl; v.en = e; v.done = d;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, ready_o, busy_o, round_o, sel_init_o, en_reg_o, done_o};
  endfunction

  initial begin
    int ndone;
    int done_at[2];
    int en_cnt;
    int done_cnt;

    reset_i  = 1'b1;
    start_i  = 1'b0;
    rounds_i = 4'd0;
    abort_i  = 1'b0;

    // Vector table: inputs driven for one cycle, outputs expected in that same cycle.
    // rounds_i=0 is ignored
    push(1, 0, 0, 1, 0, 4'd0, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd0, 0, 0, 0);
    // p^b N=6: rounds 6..11, start in DONE ignored and not queued
    push(1, 6, 0, 1, 0, 4'd0, 0, 0, 0);
    for (int k = 6; k <= 11; k++) push(0, 0, 0, 0, 1, 4'(k), k == 6, 1, 0);
    push(1, 3, 0, 0, 0, 4'd11, 0, 0, 1);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    // N=1: single round at index 11
    push(1, 1, 0, 1, 0, 4'd11, 0, 0, 0);
    push(0, 0, 0, 0, 1, 4'd11, 1, 1, 0);
    push(0, 0, 0, 0, 0, 4'd11, 0, 0, 1);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    // abort beats start in IDLE
    push(1, 5, 1, 1, 0, 4'd11, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    // rounds_i=15 saturates to 12; start re-pulsed with N=6 mid-run changes nothing
    push(1, 15, 0, 1, 0, 4'd11, 0, 0, 0);
    for (int k = 0; k <= 11; k++) push(k == 2, 6, 0, 0, 1, 4'(k), k == 0, 1, 0);
    push(0, 0, 0, 0, 0, 4'd11, 0, 0, 1);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    // abort at round 3: no load that cycle, round index held, back to IDLE
    push(1, 12, 0, 1, 0, 4'd11, 0, 0, 0);
    for (int k = 0; k <= 2; k++) push(0, 0, 0, 0, 1, 4'(k), k == 0, 1, 0);
    push(0, 0, 1, 0, 1, 4'd3, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd3, 0, 0, 0);
    // abort in DONE suppresses done_o
    push(1, 1, 0, 1, 0, 4'd3, 0, 0, 0);
    push(0, 0, 0, 0, 1, 4'd11, 1, 1, 0);
    push(0, 0, 1, 0, 0, 4'd11, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd11, 0, 0, 0);
    // abort in FIRST suppresses sel/en
    push(1, 2, 0, 1, 0, 4'd11, 0, 0, 0);
    push(0, 0, 1, 0, 1, 4'd10, 0, 0, 0);
    push(0, 0, 0, 1, 0, 4'd10, 0, 0, 0);

    #12;
    check("reset_state", outs(), {23'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clock_i);
    reset_i = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock_i);
      start_i  = vq[i].start;
      rounds_i = vq[i].rounds;
      abort_i  = vq[i].abort;
      #1;
      check($sformatf("vec%0d", i), outs(),
            {23'd0, vq[i].ready, vq[i].busy, vq[i].round, vq[i].sel, vq[i].en, vq[i].done});
    end

    // Back-to-back N=8: start held from the IDLE cycle after the first done_o.
    ndone = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_i);
      start_i  = (i == 0) || (ndone == 1);
      rounds_i = 4'd8;
      abort_i  = 1'b0;
      #1;
      if (sel_init_o) check($sformatf("b2b_first_round_c%0d", i), 32'(round_o), 32'd4);
      if (done_o && ndone < 2) begin
        done_at[ndone] = i;
        ndone++;
      end
    end
    start_i = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_done_cycle", 32'(done_at[0]), 32'd9);
    check("b2b_done_spacing", 32'(done_at[1] - done_at[0]), 32'd10);

    // Reset mid-run: asynchronous return to idle outputs, no done_o afterwards.
    @(negedge clock_i);
    start_i  = 1'b1;
    rounds_i = 4'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      start_i = 1'b0;
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset_outs", outs(), {23'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clock_i);
    reset_i  = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock_i);
      #1;
      if (done_o) done_cnt++;
    end
    check("no_done_after_reset", 32'(done_cnt), 32'd0);

    // Fresh N=12 run after reset: 12 loads, done_o 13 cycles after acceptance.
    en_cnt = 0;
    done_at[0] = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      start_i  = (i == 0);
      rounds_i = 4'd12;
      #1;
      if (en_reg_o) en_cnt++;
      if (done_o && done_at[0] < 0) done_at[0] = i;
    end
    check("post_reset_en_cycles", 32'(en_cnt), 32'd12);
    check("post_reset_done_cycle", 32'(done_at[0]), 32'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
Name: ascon_round_ctrl

Overview:
- Sequencer for the ASCON permutation datapath: constant addition, substitution layer, then permutation diffusion, one round per clock.
- Counts rounds and drives the round-constant index.
- Drives the input-mux select (external state vs. feedback) and the state-register enable.
- Supports p^a (12 rounds) and p^b (6/8 rounds) by starting the round index at 12 - N, per the ASCON round-constant convention.

Parameters:
- MAX_ROUNDS, 12, highest round count supported; last round index is MAX_ROUNDS-1
- ROUND_W, 4, width of round index and round-count ports

Ports:
- clock_i  in  1  single system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request a permutation run; accepted only when ready_o=1
- rounds_i  in  ROUND_W  number of rounds N, sampled at start acceptance
- abort_i  in  1  cancel current run, synchronous
- ready_o  out  1  controller idle, start_i will be accepted
- busy_o  out  1  run in progress (FIRST or RUN state)
- round_o  out  ROUND_W  round-constant index for the constant-addition layer
- sel_init_o  out  1  1 = datapath input mux selects external state, 0 = feedback
- en_reg_o  out  1  state-register load enable
- done_o  out  1  one-cycle pulse, permutation result valid in state register

Behaviour:
- Reset (async, reset_i=1):
  - FSM goes to IDLE and round_o=0.
  - sel_init_o=0, en_reg_o=0, busy_o=0, done_o=0, ready_o=1.
  - Reset mid-run discards the run and emits no done_o.
- FSM states: IDLE, FIRST, RUN, DONE.
- Output decode (from state only, except the abort gating):
  - IDLE: ready_o=1, all other control outputs 0.
  - FIRST: sel_init_o=1, en_reg_o=1, busy_o=1.
  - RUN: en_reg_o=1, busy_o=1.
  - DONE: done_o=1, all others 0.
- IDLE -> FIRST: on start_i=1 with rounds_i!=0 and abort_i=0.
  - Same edge loads round_o <= MAX_ROUNDS - Nsat, where Nsat = min(rounds_i, MAX_ROUNDS).
  - rounds_i=0: start ignored, stays IDLE.
  - rounds_i>MAX_ROUNDS: saturates to MAX_ROUNDS.
- FIRST and RUN: each cycle the register captures one round using the current round_o.
  - If round_o != MAX_ROUNDS-1: round_o increments, next state RUN.
  - If round_o == MAX_ROUNDS-1: next state DONE, round_o holds.
- DONE -> IDLE unconditionally. done_o is high exactly one cycle.
- Latency:
  - Start accepted at edge t gives en_reg_o high for exactly Nsat cycles, the first with sel_init_o=1.
  - done_o is high in cycle t+Nsat+1.
- Nsat=1: FIRST goes directly to DONE; only round index 11 is used.
- round_o never exceeds MAX_ROUNDS-1 and never wraps. round_o is held (not cleared) in DONE/IDLE until the next accepted start.
- start_i while busy or in DONE: ignored, not queued; rounds_i changes are ignored.
- abort_i=1 in FIRST/RUN/DONE:
  - en_reg_o and sel_init_o are forced to 0 combinationally in that cycle.
  - done_o is forced to 0.
  - Next state is IDLE.
- abort_i and start_i both high in IDLE: abort wins, no start.
- Back-to-back: start_i asserted in the IDLE cycle directly after DONE is accepted. Minimum run-to-run spacing is Nsat+2 cycles.

Test Plan:
- Reset mid-run: start with N=12, assert reset_i after 5 cycles. Required: outputs return asynchronously to the reset values listed above (ready_o=1, others 0); no done_o; a following start is accepted normally.
- p^a, N=12:
  - round_o = 0,1,...,11 over 12 en_reg_o cycles; sel_init_o=1 only in the first.
  - done_o pulses at t+13. Paired with the datapath, result equals the ASCON p^12 reference vector.
- p^b, N=6: round_o = 6..11 (constants 0x96,0x87,0x78,0x69,0x5a,0x4b), en_reg_o for 6 cycles, done_o at t+7.
- Boundary counts:
  - rounds_i=0: no response, ready_o stays 1.
  - rounds_i=15: saturates, behaves as N=12 (round_o starts at 0).
  - rounds_i=1: single cycle at round 11, done_o at t+2.
- Abort and ignored start:
  - start_i re-pulsed during RUN with rounds_i=6 changes nothing.
  - abort_i at round_o=3: en_reg_o=0 that cycle, IDLE next, no done_o.
  - abort_i+start_i in IDLE: stays IDLE.
- Back-to-back: start (N=8) then start held high from the cycle after done_o. Required: second run begins in the next IDLE cycle, round_o restarts at 4, two done_o pulses exactly 10 cycles apart.
